// File: rtl/pte_fetch_arbiter_pkg.sv
// Shared PTE-walk definitions: walker FSM encodings, PTE width and field positions.
// Pure declarations: no timing and no flow control of its own.
package pte_fetch_arbiter_pkg;

  typedef enum logic [1:0] {
    PTW_IDLE  = 2'd0,
    PTW_READ  = 2'd1,
    PTW_DRAIN = 2'd2,
    PTW_RESP  = 2'd3
  } ptw_state_e;

  localparam int PTE_W = 32;

  // Sv32 PTE field positions consumed by the MMU units.
  localparam int PTE_BIT_V   = 0;
  localparam int PTE_BIT_R   = 1;
  localparam int PTE_BIT_W   = 2;
  localparam int PTE_BIT_X   = 3;
  localparam int PTE_BIT_U   = 4;
  localparam int PTE_BIT_G   = 5;
  localparam int PTE_BIT_A   = 6;
  localparam int PTE_BIT_D   = 7;
  localparam int PTE_PPN_LSB = 10;

  function automatic int beats_for(input int beat_bytes);
    return (PTE_W / 8) / beat_bytes;
  endfunction

endpackage

// File: rtl/pte_fetch_arbiter_if.sv
// Requester, flush and memory-side bundle of the PTE fetch engine.
// The slave modport is the engine; the master modport is its environment.
interface pte_fetch_arbiter_if #(
  parameter int N_REQ      = 2,
  parameter int BEAT_BYTES = 1,
  parameter int ADDR_W     = 32
);
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic                    flush;
  logic [N_REQ-1:0]        resp_valid;
  logic                    resp_err;
  logic [31:0]             resp_pte;
  logic                    busy;
  logic                    mem_rd_en;
  logic [ADDR_W-1:0]       mem_addr;
  logic [8*BEAT_BYTES-1:0] mem_rdata;

  modport master (
    output req_valid, req_addr, flush, mem_rdata,
    input  resp_valid, resp_err, resp_pte, busy, mem_rd_en, mem_addr
  );

  modport slave (
    input  req_valid, req_addr, flush, mem_rdata,
    output resp_valid, resp_err, resp_pte, busy, mem_rd_en, mem_addr
  );
endinterface

// File: rtl/pte_fetch_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
// Zero latency; grants nothing while en is low.
module rr_arbiter #(
  parameter int N = 2,
  localparam int IDW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  input  logic           en,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] id
);
  int lo_pick;
  int hi_pick;
  int pick;

  // Descending scan leaves the lowest set index overall and the lowest at/above ptr.
  always_comb begin
    lo_pick = -1;
    hi_pick = -1;
    for (int j = N - 1; j >= 0; j--) begin
      if (req[j]) begin
        lo_pick = j;
        if (j >= int'(ptr)) hi_pick = j;
      end
    end
    pick = (hi_pick >= 0) ? hi_pick : lo_pick;
    for (int j = 0; j < N; j++) gnt[j] = en && (pick == j);
    id = (en && pick >= 0) ? IDW'(pick) : '0;
  end
endmodule

// File: rtl/pte_fetch_arbiter.sv
// Round-robin shared PTE fetch: reads one aligned 32-bit PTE in beats and pulses it back to the granted requester.
// Grant-to-response NBEATS+2 cycles (1 for misaligned); requests are level-held, flush aborts any walk without a pulse.
module pte_fetch_arbiter
  import pte_fetch_arbiter_pkg::*;
#(
  parameter int N_REQ      = 2,
  parameter int BEAT_BYTES = 1,
  parameter int ADDR_W     = 32,
  parameter int BIG_ENDIAN = 0
) (
  input logic                clk,
  input logic                rst_n,
  pte_fetch_arbiter_if.slave bus
);
  localparam int NBEATS = beats_for(BEAT_BYTES);
  localparam int CNT_W  = $clog2(NBEATS) + 1;
  localparam int IDW    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int BW     = 8 * BEAT_BYTES;
  localparam int BSH    = $clog2(BEAT_BYTES);

  ptw_state_e        state, state_nxt;
  logic [IDW-1:0]    ptr, ptr_nxt;
  logic [IDW-1:0]    gnt_id, gnt_id_nxt;
  logic [ADDR_W-1:0] base, base_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              err, err_nxt;
  logic [PTE_W-1:0]  acc, acc_nxt;
  logic [PTE_W-1:0]  pte_q;

  logic [N_REQ-1:0]  arb_gnt;
  logic [IDW-1:0]    arb_id;
  logic [ADDR_W-1:0] sel_addr;
  logic              cap_en;
  logic [CNT_W-1:0]  cap_idx;

  rr_arbiter #(.N(N_REQ)) u_rr (
    .req (bus.req_valid),
    .ptr (ptr),
    .en  (state == PTW_IDLE && !bus.flush),
    .gnt (arb_gnt),
    .id  (arb_id)
  );

  always_comb begin
    sel_addr = '0;
    for (int j = 0; j < N_REQ; j++) begin
      if (arb_gnt[j]) sel_addr = bus.req_addr[j*ADDR_W +: ADDR_W];
    end
  end

  always_comb begin
    state_nxt  = state;
    ptr_nxt    = ptr;
    gnt_id_nxt = gnt_id;
    base_nxt   = base;
    cnt_nxt    = cnt;
    err_nxt    = err;
    case (state)
      PTW_IDLE: begin
        if (|arb_gnt) begin
          gnt_id_nxt = arb_id;
          base_nxt   = sel_addr;
          cnt_nxt    = '0;
          if (sel_addr[1:0] != 2'b00) begin
            err_nxt   = 1'b1;
            state_nxt = PTW_RESP;
          end else begin
            err_nxt   = 1'b0;
            state_nxt = PTW_READ;
          end
        end
      end
      PTW_READ: begin
        if (bus.flush) begin
          state_nxt = PTW_IDLE;
        end else begin
          cnt_nxt = cnt + 1'b1;
          if (cnt == CNT_W'(NBEATS - 1)) state_nxt = PTW_DRAIN;
        end
      end
      PTW_DRAIN: state_nxt = bus.flush ? PTW_IDLE : PTW_RESP;
      // The pulse in RESP is already committed, so flush does not cancel it here.
      PTW_RESP: begin
        ptr_nxt   = (gnt_id == IDW'(N_REQ - 1)) ? '0 : gnt_id + 1'b1;
        state_nxt = PTW_IDLE;
      end
      default: state_nxt = PTW_IDLE;
    endcase
  end

  // Data trails the read strobe by one cycle, so cnt-1 is the beat on mem_rdata.
  assign cap_en  = !bus.flush && ((state == PTW_READ && cnt != '0) || state == PTW_DRAIN);
  assign cap_idx = cnt - 1'b1;

  for (genvar b = 0; b < NBEATS; b++) begin : g_beat
    localparam int LSB = (BIG_ENDIAN != 0) ? (PTE_W - BW * (b + 1)) : (BW * b);
    assign acc_nxt[LSB +: BW] = (cap_en && cap_idx == CNT_W'(b)) ? bus.mem_rdata : acc[LSB +: BW];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= PTW_IDLE;
      ptr    <= '0;
      gnt_id <= '0;
      base   <= '0;
      cnt    <= '0;
      err    <= 1'b0;
      acc    <= '0;
      pte_q  <= '0;
    end else begin
      state  <= state_nxt;
      ptr    <= ptr_nxt;
      gnt_id <= gnt_id_nxt;
      base   <= base_nxt;
      cnt    <= cnt_nxt;
      err    <= err_nxt;
      acc    <= acc_nxt;
      if (state == PTW_DRAIN && !bus.flush) pte_q <= acc_nxt;
    end
  end

  assign bus.busy      = (state != PTW_IDLE);
  assign bus.mem_rd_en = (state == PTW_READ);
  assign bus.mem_addr  = (state == PTW_READ) ? base + (ADDR_W'(cnt) << BSH) : '0;
  assign bus.resp_err  = (state == PTW_RESP) && err;
  assign bus.resp_pte  = pte_q;

  always_comb begin
    for (int j = 0; j < N_REQ; j++) begin
      bus.resp_valid[j] = (state == PTW_RESP) && (gnt_id == IDW'(j));
    end
  end
endmodule

// File: tb/tb_pte_fetch_arbiter.sv
// Bench for pte_fetch_arbiter: byte-beat little-endian and word-beat big-endian instances,
// responses scored against an expected-response queue per instance.
module tb_pte_fetch_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  typedef struct {
    int          id;
    logic [31:0] pte;
    logic        err;
  } exp_t;

  exp_t sb_a[$];
  exp_t sb_b[$];
  exp_t ea;
  exp_t eb;

  pte_fetch_arbiter_if #(.N_REQ(2), .BEAT_BYTES(1), .ADDR_W(32)) ifa ();
  pte_fetch_arbiter_if #(.N_REQ(2), .BEAT_BYTES(4), .ADDR_W(32)) ifb ();

  pte_fetch_arbiter #(.N_REQ(2), .BEAT_BYTES(1), .ADDR_W(32), .BIG_ENDIAN(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa)
  );
  pte_fetch_arbiter #(.N_REQ(2), .BEAT_BYTES(4), .ADDR_W(32), .BIG_ENDIAN(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb)
  );

  function automatic logic [7:0] mb(input logic [31:0] a);
    case (a)
      32'h100: return 8'hEF;
      32'h101: return 8'hBE;
      32'h102: return 8'hAD;
      32'h103: return 8'hDE;
      default: return a[7:0] ^ a[15:8] ^ 8'h5A;
    endcase
  endfunction

  function automatic logic [31:0] pa(input logic [31:0] a);
    return {mb(a + 32'd3), mb(a + 32'd2), mb(a + 32'd1), mb(a)};
  endfunction

  function automatic logic [31:0] mw(input logic [31:0] a);
    return (a == 32'h200) ? 32'h11223344 : {a[15:0] ^ 16'hA5A5, a[15:0]};
  endfunction

  function automatic exp_t mk(input int id, input logic [31:0] pte, input logic err);
    exp_t e;
    e.id = id;
    e.pte = pte;
    e.err = err;
    return e;
  endfunction

  // Memory: read data appears one cycle after the strobe.
  always @(posedge clk) if (ifa.mem_rd_en) ifa.mem_rdata <= mb(ifa.mem_addr);
  always @(posedge clk) if (ifb.mem_rd_en) ifb.mem_rdata <= mw(ifb.mem_addr);

  always @(negedge clk) begin
    if (rst_n && |ifa.resp_valid) begin
      checks++;
      if (sb_a.size() == 0) begin
        $display("FAIL a_unsolicited resp_valid=%b expected no pulse", ifa.resp_valid);
      end else begin
        ea = sb_a.pop_front();
        if (ifa.resp_valid !== (2'b01 << ea.id) || ifa.resp_err !== ea.err ||
            (!ea.err && ifa.resp_pte !== ea.pte))
          $display("FAIL a_resp got vld=%b err=%b pte=%h expected vld=%b err=%b pte=%h",
                   ifa.resp_valid, ifa.resp_err, ifa.resp_pte, 2'b01 << ea.id, ea.err, ea.pte);
        else passed++;
      end
    end
    if (rst_n && |ifb.resp_valid) begin
      checks++;
      if (sb_b.size() == 0) begin
        $display("FAIL b_unsolicited resp_valid=%b expected no pulse", ifb.resp_valid);
      end else begin
        eb = sb_b.pop_front();
        if (ifb.resp_valid !== (2'b01 << eb.id) || ifb.resp_err !== eb.err ||
            (!eb.err && ifb.resp_pte !== eb.pte))
          $display("FAIL b_resp got vld=%b err=%b pte=%h expected vld=%b err=%b pte=%h",
                   ifb.resp_valid, ifb.resp_err, ifb.resp_pte, 2'b01 << eb.id, eb.err, eb.pte);
        else passed++;
      end
    end
  end

  task automatic wait_pulse_a(input int limit, output int cyc);
    cyc = -1;
    for (int k = 1; k <= limit; k++) begin
      @(negedge clk);
      if (|ifa.resp_valid) begin
        cyc = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ifa.req_valid = '0; ifa.req_addr = '0; ifa.flush = 1'b0;
    ifb.req_valid = '0; ifb.req_addr = '0; ifb.flush = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({ifa.resp_valid, ifa.resp_err, ifa.busy, ifa.mem_rd_en} !== 5'b0 ||
        ifa.mem_addr !== 32'h0 || ifa.resp_pte !== 32'h0)
      $display("FAIL reset_a got vld=%b err=%b busy=%b rd=%b addr=%h pte=%h expected all 0",
               ifa.resp_valid, ifa.resp_err, ifa.busy, ifa.mem_rd_en, ifa.mem_addr, ifa.resp_pte);
    else passed++;
    checks++;
    if ({ifb.resp_valid, ifb.resp_err, ifb.busy, ifb.mem_rd_en} !== 5'b0 ||
        ifb.mem_addr !== 32'h0 || ifb.resp_pte !== 32'h0)
      $display("FAIL reset_b got vld=%b err=%b busy=%b rd=%b addr=%h pte=%h expected all 0",
               ifb.resp_valid, ifb.resp_err, ifb.busy, ifb.mem_rd_en, ifb.mem_addr, ifb.resp_pte);
    else passed++;
    #2 rst_n = 1'b1;
  endtask

  task automatic test_single();
    logic       exp_rd;
    logic [1:0] exp_vld;
    @(negedge clk);
    ifa.req_addr[31:0] = 32'h100;
    ifa.req_valid = 2'b01;
    sb_a.push_back(mk(0, 32'hDEADBEEF, 1'b0));
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      exp_rd  = (k <= 4);
      exp_vld = (k == 6) ? 2'b01 : 2'b00;
      checks++;
      if (ifa.mem_rd_en !== exp_rd || (exp_rd && ifa.mem_addr !== 32'(32'h100 + k - 1)) ||
          ifa.resp_valid !== exp_vld)
        $display("FAIL single_cyc%0d got rd=%b addr=%h vld=%b expected rd=%b addr=%h vld=%b",
                 k, ifa.mem_rd_en, ifa.mem_addr, ifa.resp_valid, exp_rd, 32'(32'h100 + k - 1), exp_vld);
      else passed++;
      if (k == 6) ifa.req_valid = 2'b00;
    end
  endtask

  task automatic test_be4();
    logic       exp_rd;
    logic [1:0] exp_vld;
    @(negedge clk);
    ifb.req_addr[31:0] = 32'h200;
    ifb.req_valid = 2'b01;
    sb_b.push_back(mk(0, 32'h11223344, 1'b0));
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      exp_rd  = (k == 1);
      exp_vld = (k == 3) ? 2'b01 : 2'b00;
      checks++;
      if (ifb.mem_rd_en !== exp_rd || (exp_rd && ifb.mem_addr !== 32'h200) || ifb.resp_valid !== exp_vld)
        $display("FAIL be4_cyc%0d got rd=%b addr=%h vld=%b expected rd=%b addr=00000200 vld=%b",
                 k, ifb.mem_rd_en, ifb.mem_addr, ifb.resp_valid, exp_rd, exp_vld);
      else passed++;
      if (k == 3) ifb.req_valid = 2'b00;
    end
  endtask

  task automatic test_misaligned();
    @(negedge clk);
    ifa.req_addr[63:32] = 32'h102;
    ifa.req_valid = 2'b10;
    sb_a.push_back(mk(1, 32'h0, 1'b1));
    @(negedge clk);
    checks++;
    if (ifa.resp_valid !== 2'b10 || ifa.resp_err !== 1'b1 || ifa.mem_rd_en !== 1'b0)
      $display("FAIL misaligned got vld=%b err=%b rd=%b expected vld=10 err=1 rd=0",
               ifa.resp_valid, ifa.resp_err, ifa.mem_rd_en);
    else passed++;
    ifa.req_valid = 2'b00;
    @(negedge clk);
    checks++;
    if (ifa.mem_rd_en !== 1'b0 || ifa.busy !== 1'b0)
      $display("FAIL misaligned_after got rd=%b busy=%b expected rd=0 busy=0", ifa.mem_rd_en, ifa.busy);
    else passed++;
  endtask

  task automatic test_fairness();
    int seen = 0;
    ifa.req_addr = {32'h400, 32'h300};
    for (int i = 0; i < 4; i++)
      sb_a.push_back(mk(i % 2, (i % 2 == 0) ? pa(32'h300) : pa(32'h400), 1'b0));
    ifa.req_valid = 2'b11;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (|ifa.resp_valid) begin
        checks++;
        if (ifa.resp_valid !== (2'b01 << (seen % 2)))
          $display("FAIL fair_pulse%0d got vld=%b expected vld=%b", seen, ifa.resp_valid, 2'b01 << (seen % 2));
        else passed++;
        seen++;
        if (seen == 4) begin
          ifa.req_valid = 2'b00;
          break;
        end
      end
    end
    checks++;
    if (seen != 4) $display("FAIL fair_count got %0d pulses expected 4", seen);
    else passed++;
    ifa.req_valid = 2'b00;
  endtask

  task automatic test_flush();
    int cyc;
    @(negedge clk);
    ifa.req_addr[31:0] = 32'h500;
    ifa.req_valid = 2'b01;
    ifa.flush = 1'b1;
    @(negedge clk);
    checks++;
    if (ifa.busy !== 1'b0) $display("FAIL flush_idle got busy=%b expected 0", ifa.busy);
    else passed++;
    ifa.flush = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (ifa.mem_rd_en !== 1'b1 || ifa.mem_addr !== 32'h502)
      $display("FAIL flush_beat2 got rd=%b addr=%h expected rd=1 addr=00000502", ifa.mem_rd_en, ifa.mem_addr);
    else passed++;
    ifa.flush = 1'b1;
    ifa.req_valid = 2'b00;
    @(negedge clk);
    checks++;
    if (ifa.busy !== 1'b0 || ifa.mem_rd_en !== 1'b0 || ifa.resp_valid !== 2'b00)
      $display("FAIL flush_abort got busy=%b rd=%b vld=%b expected 0 0 00",
               ifa.busy, ifa.mem_rd_en, ifa.resp_valid);
    else passed++;
    ifa.flush = 1'b0;
    repeat (8) @(negedge clk);
    // Both request; an unchanged pointer must still pick requester 0.
    ifa.req_addr = {32'h800, 32'h500};
    ifa.req_valid = 2'b11;
    sb_a.push_back(mk(0, pa(32'h500), 1'b0));
    wait_pulse_a(20, cyc);
    ifa.req_valid = 2'b00;
    checks++;
    if (cyc != 6) $display("FAIL flush_refetch_latency got %0d expected 6", cyc);
    else passed++;
  endtask

  task automatic test_async_reset();
    int cyc;
    @(negedge clk);
    ifa.req_addr[31:0] = 32'h600;
    ifa.req_valid = 2'b01;
    ifb.req_addr[31:0] = 32'h204;
    ifb.req_valid = 2'b01;
    repeat (2) @(negedge clk);
    checks++;
    if (ifa.mem_rd_en !== 1'b1) $display("FAIL async_pre got rd=%b expected 1", ifa.mem_rd_en);
    else passed++;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({ifa.resp_valid, ifa.resp_err, ifa.busy, ifa.mem_rd_en} !== 5'b0 ||
        ifa.mem_addr !== 32'h0 || ifa.resp_pte !== 32'h0)
      $display("FAIL async_a got vld=%b err=%b busy=%b rd=%b addr=%h pte=%h expected all 0",
               ifa.resp_valid, ifa.resp_err, ifa.busy, ifa.mem_rd_en, ifa.mem_addr, ifa.resp_pte);
    else passed++;
    checks++;
    if ({ifb.resp_valid, ifb.resp_err, ifb.busy, ifb.mem_rd_en} !== 5'b0 ||
        ifb.mem_addr !== 32'h0 || ifb.resp_pte !== 32'h0)
      $display("FAIL async_b got vld=%b err=%b busy=%b rd=%b addr=%h pte=%h expected all 0",
               ifb.resp_valid, ifb.resp_err, ifb.busy, ifb.mem_rd_en, ifb.mem_addr, ifb.resp_pte);
    else passed++;
    ifa.req_valid = 2'b00;
    ifb.req_valid = 2'b00;
    @(negedge clk);
    ifa.req_addr = {32'h700, 32'h600};
    ifa.req_valid = 2'b11;
    sb_a.push_back(mk(0, pa(32'h600), 1'b0));
    #2 rst_n = 1'b1;
    wait_pulse_a(20, cyc);
    ifa.req_valid = 2'b00;
    checks++;
    if (cyc != 6) $display("FAIL async_restart_latency got %0d expected 6", cyc);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_be4();
    test_misaligned();
    test_fairness();
    test_flush();
    test_async_reset();
    repeat (10) @(negedge clk);
    checks++;
    if (sb_a.size() != 0) $display("FAIL a_pending got %0d outstanding expected 0", sb_a.size());
    else passed++;
    checks++;
    if (sb_b.size() != 0) $display("FAIL b_pending got %0d outstanding expected 0", sb_b.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish within 100000 time units");
    $fatal(1);
  end
endmodule
